// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter, 8N1 by default; define UART_TX_PARITY_EN for 8E1 (even parity bit).
module uart_tx_core #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx,
  output logic       o_tx_busy,
  output logic       o_tx_done
);
  localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(BIT_CYC);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic tx_d, busy_d, done_d, bit_end;
  assign bit_end = cnt_q == LAST;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      o_tx      <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      o_tx      <= tx_d;
      o_tx_busy <= busy_d;
      o_tx_done <= done_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = o_tx;
    busy_d  = o_tx_busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (i_tx_start) begin
          sh_d    = i_tx_data;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START:
        if (bit_end) begin
          idx_d   = '0;
          tx_d    = sh_q[0];
          state_d = DATA;
        end
      DATA:
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = ^sh_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = sh_q[idx_q + 3'd1];
          end
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
`endif
      STOP:
        if (bit_end) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
endmodule
